// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch-stage PC unit.
package cpu_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned JIDX_W     = 26;
    localparam int unsigned BOOT_CNT_W = 4;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t RESET_VECTOR_DEF = 32'h0000_0000;
    localparam word_t EXC_VECTOR_DEF   = 32'h0000_0180;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_EXC  = 2'd2
    } pc_state_e;

    // Candidate next-PC values produced from the ID-stage fields.
    typedef struct packed {
        word_t branch;
        word_t jump;
        word_t jr;
        logic  jr_misaligned;
    } pc_targets_t;

endpackage

// File: rtl/pc_unit_if.sv
// Bus between the ID/hazard side (master) and the PC unit (slave).
interface pc_unit_if;
    import cpu_pkg::*;

    logic              Stall;
    word_t             IdPCPlus4;
    logic              Branch;
    word_t             BranchOffset;
    logic              Jump;
    logic [JIDX_W-1:0] JumpIndex;
    logic              JumpReg;
    word_t             RegTarget;

    word_t             PC;
    word_t             PCPlus4;
    logic              FetchValid;
    logic              Flush;
    logic              AddrErr;
    word_t             EPC;
    word_t             BadVAddr;

    modport master (
        output Stall, IdPCPlus4, Branch, BranchOffset, Jump, JumpIndex, JumpReg, RegTarget,
        input  PC, PCPlus4, FetchValid, Flush, AddrErr, EPC, BadVAddr
    );

    modport slave (
        input  Stall, IdPCPlus4, Branch, BranchOffset, Jump, JumpIndex, JumpReg, RegTarget,
        output PC, PCPlus4, FetchValid, Flush, AddrErr, EPC, BadVAddr
    );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational branch / jump / jump-register target computation.
module pc_target_calc
    import cpu_pkg::*;
(
    input  word_t             id_pc_plus4_i,
    input  word_t             branch_offset_i,
    input  logic [JIDX_W-1:0] jump_index_i,
    input  word_t             reg_target_i,
    output pc_targets_t       targets_o
);

    // The top two offset bits fall off the word shift.
    logic offset_unused;
    assign offset_unused = ^branch_offset_i[WORD_W-1:WORD_W-2];

    // Targets are modulo-2^32; jump keeps the current 256 MB region.
    always_comb begin
        targets_o.branch        = id_pc_plus4_i + {branch_offset_i[WORD_W-3:0], 2'b00};
        targets_o.jump          = {id_pc_plus4_i[WORD_W-1:WORD_W-4], jump_index_i, 2'b00};
        targets_o.jr            = reg_target_i;
        targets_o.jr_misaligned = |reg_target_i[1:0];
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter and next-PC selection for the fetch stage.
// Build option: define PC_DELAY_SLOT_EN for branch-delay-slot semantics
// (taken redirects do not flush IF); the trap path always flushes.
module pc_unit
    import cpu_pkg::*;
#(
    parameter word_t       RESET_VECTOR = RESET_VECTOR_DEF,
    parameter word_t       EXC_VECTOR   = EXC_VECTOR_DEF,
    parameter int unsigned BOOT_CYCLES  = 2
)(
    input logic      Clk,
    input logic      Rst,
    pc_unit_if.slave pc_if
);

    // BOOT_CYCLES of 0 and 1 both leave BOOT on its first cycle.
    localparam int unsigned BOOT_LAST = (BOOT_CYCLES == 0) ? 0 : BOOT_CYCLES - 1;

`ifdef PC_DELAY_SLOT_EN
    localparam logic REDIRECT_FLUSH = 1'b0;
`else
    localparam logic REDIRECT_FLUSH = 1'b1;
`endif

    pc_state_e             state_q, state_d;
    logic [BOOT_CNT_W-1:0] boot_cnt_q, boot_cnt_d;
    word_t                 pc_q, pc_d;
    word_t                 epc_q, epc_d;
    word_t                 bad_vaddr_q, bad_vaddr_d;
    logic                  fetch_valid_q, fetch_valid_d;
    logic                  addr_err_q, addr_err_d;
    logic                  flush_c;
    logic                  boot_done_c;
    logic                  run_go_c;
    logic                  trap_c;
    word_t                 pc_plus4_c;
    pc_targets_t           targets;

    pc_target_calc u_target_calc (
        .id_pc_plus4_i   (pc_if.IdPCPlus4),
        .branch_offset_i (pc_if.BranchOffset),
        .jump_index_i    (pc_if.JumpIndex),
        .reg_target_i    (pc_if.RegTarget),
        .targets_o       (targets)
    );

    assign pc_plus4_c  = pc_q + WORD_W'(4);
    assign boot_done_c = (boot_cnt_q == BOOT_CNT_W'(BOOT_LAST));
    assign run_go_c    = (state_q == ST_RUN) && !pc_if.Stall;
    assign trap_c      = run_go_c && pc_if.JumpReg && targets.jr_misaligned;

    // FSM state register and boot counter.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

    // Next-state: boot delay, trap entry, single-cycle exception state.
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        case (state_q)
            ST_BOOT: begin
                boot_cnt_d = boot_cnt_q + BOOT_CNT_W'(1);
                if (boot_done_c) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (trap_c) begin
                    state_d = ST_EXC;
                end
            end
            ST_EXC: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Outputs: next-PC priority mux, trap capture and IF flush.
    always_comb begin
        pc_d        = pc_q;
        epc_d       = epc_q;
        bad_vaddr_d = bad_vaddr_q;
        flush_c     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (run_go_c) begin
                    if (trap_c) begin
                        epc_d       = pc_if.IdPCPlus4 - WORD_W'(4);
                        bad_vaddr_d = pc_if.RegTarget;
                        flush_c     = 1'b1;
                    end else if (pc_if.JumpReg) begin
                        pc_d    = targets.jr;
                        flush_c = REDIRECT_FLUSH;
                    end else if (pc_if.Jump) begin
                        pc_d    = targets.jump;
                        flush_c = REDIRECT_FLUSH;
                    end else if (pc_if.Branch) begin
                        pc_d    = targets.branch;
                        flush_c = REDIRECT_FLUSH;
                    end else begin
                        pc_d = pc_plus4_c;
                    end
                end
            end
            ST_EXC: begin
                pc_d    = EXC_VECTOR;
                flush_c = 1'b1;
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
        if (!Rst) begin
            flush_c = 1'b0;
        end
        fetch_valid_d = (state_d == ST_RUN);
        addr_err_d    = (state_d == ST_EXC);
    end

    // Datapath registers; trap info holds until the next trap or reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            pc_q          <= RESET_VECTOR;
            epc_q         <= '0;
            bad_vaddr_q   <= '0;
            fetch_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            bad_vaddr_q   <= bad_vaddr_d;
            fetch_valid_q <= fetch_valid_d;
            addr_err_q    <= addr_err_d;
        end
    end

    assign pc_if.PC         = pc_q;
    assign pc_if.PCPlus4    = pc_plus4_c;
    assign pc_if.FetchValid = fetch_valid_q;
    assign pc_if.Flush      = flush_c;
    assign pc_if.AddrErr    = addr_err_q;
    assign pc_if.EPC        = epc_q;
    assign pc_if.BadVAddr   = bad_vaddr_q;

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_pc_unit;
    import cpu_pkg::*;

    localparam int unsigned BOOT_CYCLES = 2;
    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] EV = 32'h0000_0180;
`ifdef PC_DELAY_SLOT_EN
    localparam logic REDIR_FLUSH = 1'b0;
`else
    localparam logic REDIR_FLUSH = 1'b1;
`endif

    logic Clk = 1'b0;
    logic Rst = 1'b0;

    pc_unit_if u_if ();

    pc_unit #(
        .RESET_VECTOR (RV),
        .EXC_VECTOR   (EV),
        .BOOT_CYCLES  (BOOT_CYCLES)
    ) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .pc_if (u_if)
    );

    always #5 Clk = ~Clk;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    // Behavioural model: PC value, boot cycles still to run, trap pending.
    logic [31:0] m_pc  = 32'h0;
    logic [31:0] m_epc = 32'h0;
    logic [31:0] m_bad = 32'h0;
    int          m_boot_left = 0;
    bit          m_exc = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_flush();
        if (!Rst || m_boot_left > 0) return 1'b0;
        if (m_exc) return 1'b1;
        if (u_if.Stall) return 1'b0;
        if (u_if.JumpReg && (u_if.RegTarget % 4) != 0) return 1'b1;
        if (u_if.JumpReg || u_if.Jump || u_if.Branch) return REDIR_FLUSH;
        return 1'b0;
    endfunction

    task automatic model_step();
        if (!Rst) begin
            m_pc        = RV;
            m_epc       = 32'h0;
            m_bad       = 32'h0;
            m_exc       = 1'b0;
            m_boot_left = (BOOT_CYCLES == 0) ? 1 : int'(BOOT_CYCLES);
        end else if (m_boot_left > 0) begin
            m_boot_left = m_boot_left - 1;
        end else if (m_exc) begin
            m_exc = 1'b0;
            m_pc  = EV;
        end else if (!u_if.Stall) begin
            if (u_if.JumpReg && (u_if.RegTarget % 4) != 0) begin
                m_exc = 1'b1;
                m_epc = u_if.IdPCPlus4 - 32'd4;
                m_bad = u_if.RegTarget;
            end else if (u_if.JumpReg) begin
                m_pc = u_if.RegTarget;
            end else if (u_if.Jump) begin
                m_pc = (u_if.IdPCPlus4 & 32'hF000_0000) | (32'(u_if.JumpIndex) * 4);
            end else if (u_if.Branch) begin
                m_pc = u_if.IdPCPlus4 + u_if.BranchOffset * 4;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // Model advances on each rising edge; inputs change only after it.
    always @(posedge Clk) model_step();

    // Compare every output against the model away from the active edge.
    always @(negedge Clk) begin
        if (chk_en) begin
            chk("pc",          u_if.PC,                 m_pc);
            chk("pcplus4",     u_if.PCPlus4,            m_pc + 32'd4);
            chk("fetch_valid", 32'(u_if.FetchValid),    32'(m_boot_left == 0 && !m_exc));
            chk("addr_err",    32'(u_if.AddrErr),       32'(m_exc));
            chk("epc",         u_if.EPC,                m_epc);
            chk("badvaddr",    u_if.BadVAddr,           m_bad);
            chk("flush",       32'(u_if.Flush),         32'(exp_flush()));
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge Clk);
    endtask

    task automatic set_idle();
        u_if.Stall        = 1'b0;
        u_if.IdPCPlus4    = 32'h0;
        u_if.Branch       = 1'b0;
        u_if.BranchOffset = 32'h0;
        u_if.Jump         = 1'b0;
        u_if.JumpIndex    = 26'h0;
        u_if.JumpReg      = 1'b0;
        u_if.RegTarget    = 32'h0;
    endtask

    task automatic rand_inputs();
        logic [15:0] imm;
        imm               = 16'($urandom());
        Rst               = ($urandom_range(199) != 0);
        u_if.Stall        = ($urandom_range(3) == 0);
        u_if.Branch       = ($urandom_range(3) == 0);
        u_if.Jump         = ($urandom_range(4) == 0);
        u_if.JumpReg      = ($urandom_range(4) == 0);
        u_if.IdPCPlus4    = $urandom() & 32'hFFFF_FFFC;
        u_if.BranchOffset = {{16{imm[15]}}, imm};
        u_if.JumpIndex    = 26'($urandom());
        u_if.RegTarget    = $urandom();
        if ($urandom_range(3) != 0) u_if.RegTarget[1:0] = 2'b00;
    endtask

    initial begin
        set_idle();
        Rst = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        Rst = 1'b1;

        // Reset/boot: two idle cycles, then sequential fetch from 0.
        for (int i = 0; i < 2; i++) begin
            at_neg();
            chk("boot_pc", u_if.PC, RV);
            chk("boot_fv", 32'(u_if.FetchValid), 32'd0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("run_pc", u_if.PC, 32'(4 * i));
            chk("run_fv", 32'(u_if.FetchValid), 32'd1);
            tick();
        end

        // Backward branch to 0.
        u_if.IdPCPlus4    = 32'h0000_0010;
        u_if.BranchOffset = 32'hFFFF_FFFC;
        u_if.Branch       = 1'b1;
        at_neg();
        chk("branch_flush", 32'(u_if.Flush), 32'(REDIR_FLUSH));
        tick();

        // Jump held off by a two-cycle stall.
        set_idle();
        u_if.Stall     = 1'b1;
        u_if.Jump      = 1'b1;
        u_if.JumpIndex = 26'h000_0040;
        at_neg();
        chk("branch_pc", u_if.PC, 32'h0000_0000);
        chk("stall_flush", 32'(u_if.Flush), 32'd0);
        tick();
        at_neg();
        chk("stall_hold_pc", u_if.PC, 32'h0000_0000);
        tick();
        u_if.Stall = 1'b0;
        at_neg();
        chk("jump_flush", 32'(u_if.Flush), 32'(REDIR_FLUSH));
        tick();
        set_idle();
        at_neg();
        chk("jump_pc", u_if.PC, 32'h0000_0100);
        tick();

        // Misaligned jr traps; stall is ignored in the trap cycle.
        u_if.JumpReg   = 1'b1;
        u_if.RegTarget = 32'h0000_1002;
        u_if.IdPCPlus4 = 32'h0000_0024;
        at_neg();
        chk("jr_flush", 32'(u_if.Flush), 32'd1);
        tick();
        set_idle();
        u_if.Stall = 1'b1;
        at_neg();
        chk("exc_addr_err", 32'(u_if.AddrErr), 32'd1);
        chk("exc_epc", u_if.EPC, 32'h0000_0020);
        chk("exc_badvaddr", u_if.BadVAddr, 32'h0000_1002);
        chk("exc_fv", 32'(u_if.FetchValid), 32'd0);
        chk("exc_flush", 32'(u_if.Flush), 32'd1);
        tick();
        u_if.Stall = 1'b0;
        at_neg();
        chk("vector_pc", u_if.PC, 32'h0000_0180);
        chk("vector_addr_err", 32'(u_if.AddrErr), 32'd0);
        chk("vector_fv", 32'(u_if.FetchValid), 32'd1);
        tick();

        // Jump beats branch; then sequential wrap past the top.
        u_if.Jump         = 1'b1;
        u_if.Branch       = 1'b1;
        u_if.IdPCPlus4    = 32'hF000_0000;
        u_if.JumpIndex    = 26'h3FF_FFFF;
        u_if.BranchOffset = 32'h0000_0008;
        at_neg();
        tick();
        set_idle();
        at_neg();
        chk("prio_pc", u_if.PC, 32'hFFFF_FFFC);
        chk("wrap_plus4", u_if.PCPlus4, 32'h0000_0000);
        tick();
        at_neg();
        chk("wrap_pc", u_if.PC, 32'h0000_0000);
        tick();

        // Reset asserted during the trap cycle.
        u_if.JumpReg   = 1'b1;
        u_if.RegTarget = 32'h0000_0003;
        u_if.IdPCPlus4 = 32'h0000_0040;
        at_neg();
        tick();
        set_idle();
        Rst = 1'b0;
        at_neg();
        chk("rst_exc_addr_err", 32'(u_if.AddrErr), 32'd1);
        chk("rst_exc_epc", u_if.EPC, 32'h0000_003C);
        chk("rst_exc_flush", 32'(u_if.Flush), 32'd0);
        tick();
        Rst = 1'b1;
        at_neg();
        chk("rst_pc", u_if.PC, RV);
        chk("rst_addr_err", 32'(u_if.AddrErr), 32'd0);
        chk("rst_epc", u_if.EPC, 32'h0);
        chk("rst_badvaddr", u_if.BadVAddr, 32'h0);
        chk("rst_fv", 32'(u_if.FetchValid), 32'd0);
        tick();

        // Randomized traffic, including occasional resets.
        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            tick();
        end
        Rst = 1'b1;
        set_idle();
        tick();
        at_neg();
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
